// File: rtl/opnd_writeback.sv
// rtl/opnd_writeback.sv - architectural GPR file and result-commit unit (optional WB_SCOREBOARD_EN busy mask)
module opnd_writeback #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_en,
    input  logic [31:0]         init_eax,
    input  logic [31:0]         init_ecx,
    input  logic [31:0]         init_edx,
    input  logic [31:0]         init_ebx,
    input  logic [31:0]         init_esp,
    input  logic [31:0]         init_ebp,
    input  logic [31:0]         init_esi,
    input  logic [31:0]         init_edi,
    input  logic                wb_valid,
    output logic                wb_ready,
    input  logic                wb_dst_en,
    input  logic [2:0]          wb_dst_sel,
    input  logic [31:0]         wb_dst_value,
    input  logic                wb_reg_1byte,
    input  logic                wb_operand_16bit,
    input  logic                wb_esp_en,
    input  logic [31:0]         wb_esp_value,
    output logic [31:0]         eax,
    output logic [31:0]         ecx,
    output logic [31:0]         edx,
    output logic [31:0]         ebx,
    output logic [31:0]         esp,
    output logic [31:0]         ebp,
    output logic [31:0]         esi,
    output logic [31:0]         edi,
    output logic                wb_done,
    output logic [RETIRE_W-1:0] retired,
    output logic [7:0]          busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WR_ESP = 2'd1;
    localparam logic [1:0] ST_WR_DST = 2'd2;

    logic [1:0]          r_state;
    logic [31:0]         r_gpr [8];
    logic                r_dst_en;
    logic [2:0]          r_dst_sel;
    logic [31:0]         r_dst_value;
    logic                r_byte_en;
    logic                r_w16;
    logic                r_esp_en;
    logic [31:0]         r_esp_value;
    logic                r_done;
    logic [RETIRE_W-1:0] r_retired;

    logic                w_accept;
    logic                w_byte_hi;
    logic [2:0]          w_dst_idx;

    assign wb_ready = (r_state == ST_IDLE) && !load_en;
    assign w_accept = wb_valid && wb_ready;

    // A byte write to sel 4-7 lands in bits 15:8 of register sel-4 (AH/CH/DH/BH).
    assign w_byte_hi = r_byte_en && r_dst_sel[2];
    assign w_dst_idx = w_byte_hi ? {1'b0, r_dst_sel[1:0]} : r_dst_sel;

    function automatic logic [31:0] f_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic        byte_en,
        input logic        w16,
        input logic        hi
    );
        if (byte_en) begin
            f_merge = hi ? {old_val[31:16], new_val[7:0], old_val[7:0]}
                         : {old_val[31:8], new_val[7:0]};
        end else if (w16) begin
            f_merge = {old_val[31:16], new_val[15:0]};
        end else begin
            f_merge = new_val;
        end
    endfunction

    // Commit FSM: IDLE -> (WR_ESP) -> WR_DST -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (w_accept) r_state <= wb_esp_en ? ST_WR_ESP : ST_WR_DST;
                ST_WR_ESP: r_state <= ST_WR_DST;
                ST_WR_DST: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    // Capture the whole transaction so the producer may move on after acceptance.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_dst_en    <= wb_dst_en;
            r_dst_sel   <= wb_dst_sel;
            r_dst_value <= wb_dst_value;
            r_byte_en   <= wb_reg_1byte;
            r_w16       <= wb_operand_16bit;
            r_esp_en    <= wb_esp_en;
            r_esp_value <= wb_esp_value;
        end
    end

    // Register file: bulk load in IDLE, ESP adjust first, destination merge last.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) r_gpr[i] <= 32'd0;
        end else if (r_state == ST_IDLE && load_en) begin
            r_gpr[0] <= init_eax;
            r_gpr[1] <= init_ecx;
            r_gpr[2] <= init_edx;
            r_gpr[3] <= init_ebx;
            r_gpr[4] <= init_esp;
            r_gpr[5] <= init_ebp;
            r_gpr[6] <= init_esi;
            r_gpr[7] <= init_edi;
        end else if (r_state == ST_WR_ESP) begin
            r_gpr[4] <= r_esp_value;
        end else if (r_state == ST_WR_DST && r_dst_en) begin
            r_gpr[w_dst_idx] <= f_merge(r_gpr[w_dst_idx], r_dst_value, r_byte_en, r_w16, w_byte_hi);
        end
    end

    // Retirement pulse and counter, both tied to leaving WR_DST.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done    <= 1'b0;
            r_retired <= '0;
        end else begin
            r_done <= (r_state == ST_WR_DST);
            if (r_state == ST_WR_DST) r_retired <= r_retired + {{(RETIRE_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [7:0] r_busy;
    logic [2:0] w_in_idx;

    assign w_in_idx = (wb_reg_1byte && wb_dst_sel[2]) ? {1'b0, wb_dst_sel[1:0]} : wb_dst_sel;

    // Pending-write mask: set on accept, ESP bit drops after WR_ESP unless the destination is ESP too.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept)
                        r_busy <= (wb_dst_en ? (8'h01 << w_in_idx) : 8'h00) | (wb_esp_en ? 8'h10 : 8'h00);
                    else
                        r_busy <= 8'h00;
                end
                ST_WR_ESP: r_busy <= r_dst_en ? (8'h01 << w_dst_idx) : 8'h00;
                default:   r_busy <= 8'h00;
            endcase
        end
    end

    assign busy = r_busy;
`else
    assign busy = 8'h00;
`endif

    assign eax     = r_gpr[0];
    assign ecx     = r_gpr[1];
    assign edx     = r_gpr[2];
    assign ebx     = r_gpr[3];
    assign esp     = r_gpr[4];
    assign ebp     = r_gpr[5];
    assign esi     = r_gpr[6];
    assign edi     = r_gpr[7];
    assign wb_done = r_done;
    assign retired = r_retired;

endmodule

// File: tb/tb_opnd_writeback.sv
// tb/tb_opnd_writeback.sv - directed self-checking bench for opnd_writeback
module tb_opnd_writeback;

`ifdef WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [31:0] init_eax, init_ecx, init_edx, init_ebx, init_esp, init_ebp, init_esi, init_edi;
    logic        wb_valid, wb_ready, wb_dst_en, wb_reg_1byte, wb_operand_16bit, wb_esp_en;
    logic [2:0]  wb_dst_sel;
    logic [31:0] wb_dst_value, wb_esp_value;
    logic [31:0] eax, ecx, edx, ebx, esp, ebp, esi, edi;
    logic        wb_done;
    logic [31:0] retired;
    logic [7:0]  busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    opnd_writeback #(.RETIRE_W(32)) dut (
        .clk(clk), .rst(rst), .load_en(load_en),
        .init_eax(init_eax), .init_ecx(init_ecx), .init_edx(init_edx), .init_ebx(init_ebx),
        .init_esp(init_esp), .init_ebp(init_ebp), .init_esi(init_esi), .init_edi(init_edi),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dst_en(wb_dst_en), .wb_dst_sel(wb_dst_sel),
        .wb_dst_value(wb_dst_value), .wb_reg_1byte(wb_reg_1byte), .wb_operand_16bit(wb_operand_16bit),
        .wb_esp_en(wb_esp_en), .wb_esp_value(wb_esp_value),
        .eax(eax), .ecx(ecx), .edx(edx), .ebx(ebx), .esp(esp), .ebp(ebp), .esi(esi), .edi(edi),
        .wb_done(wb_done), .retired(retired), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic dst_en, input logic [2:0] sel, input logic [31:0] val,
                         input logic b1, input logic w16, input logic e_en, input logic [31:0] e_val);
        wb_valid = 1'b1; wb_dst_en = dst_en; wb_dst_sel = sel; wb_dst_value = val;
        wb_reg_1byte = b1; wb_operand_16bit = w16; wb_esp_en = e_en; wb_esp_value = e_val;
    endtask

    task automatic scramble();
        wb_valid = 1'b0; wb_dst_en = 1'b1; wb_dst_sel = 3'd7; wb_dst_value = 32'hFFFF_FFFF;
        wb_reg_1byte = 1'b0; wb_operand_16bit = 1'b0; wb_esp_en = 1'b1; wb_esp_value = 32'hEEEE_EEEE;
    endtask

    task automatic set_init(input logic [31:0] a, input logic [31:0] d);
        init_eax = a; init_ecx = 0; init_edx = d; init_ebx = 0;
        init_esp = 0; init_ebp = 0; init_esi = 0; init_edi = 0;
    endtask

    initial begin
        rst = 1'b1; load_en = 1'b0; set_init(32'd0, 32'd0);
        wb_valid = 1'b0; wb_dst_en = 1'b0; wb_dst_sel = 3'd0; wb_dst_value = 0;
        wb_reg_1byte = 1'b0; wb_operand_16bit = 1'b0; wb_esp_en = 1'b0; wb_esp_value = 0;
        tick(); tick();
        rst = 1'b0; #1;
        check("rst_eax", eax, 32'd0);
        check("rst_esp", esp, 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_done", {31'd0, wb_done}, 32'd0);
        check("rst_busy", {24'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, wb_ready}, 32'd1);

        // Load; wb_valid offered simultaneously must not be accepted.
        set_init(32'h1122_3344, 32'd0); load_en = 1'b1;
        offer(1'b1, 3'd0, 32'h9999_9999, 1'b0, 1'b0, 1'b0, 32'd0);
        #1;
        check("load_ready_low", {31'd0, wb_ready}, 32'd0);
        tick();
        load_en = 1'b0; wb_valid = 1'b0; #1;
        check("load_eax", eax, 32'h1122_3344);
        check("load_retired", retired, 32'd0);
        check("load_ready_high", {31'd0, wb_ready}, 32'd1);
        tick();
        check("load_no_accept", eax, 32'h1122_3344);

        // AH write: sel 4, 1-byte.
        offer(1'b1, 3'd4, 32'h0000_00AB, 1'b1, 1'b0, 1'b0, 32'd0);
        tick(); scramble(); #1;
        check("ah_pending_eax", eax, 32'h1122_3344);
        check("ah_pending_ready", {31'd0, wb_ready}, 32'd0);
        check("ah_busy", {24'd0, busy}, SB ? 32'h01 : 32'h00);
        tick();
        check("ah_eax", eax, 32'h1122_AB44);
        check("ah_done", {31'd0, wb_done}, 32'd1);
        check("ah_retired", retired, 32'd1);
        check("ah_esp_untouched", esp, 32'd0);
        tick();
        check("ah_done_once", {31'd0, wb_done}, 32'd0);

        // 16-bit write into EDX.
        set_init(32'h1122_AB44, 32'hDEAD_BEEF); load_en = 1'b1; tick(); load_en = 1'b0;
        offer(1'b1, 3'd2, 32'hFFFF_5555, 1'b0, 1'b1, 1'b0, 32'd0);
        tick(); scramble(); tick();
        check("w16_edx", edx, 32'hDEAD_5555);
        check("w16_eax_kept", eax, 32'h1122_AB44);
        check("w16_retired", retired, 32'd2);

        // 8-bit low write (AL) beats 16-bit flag.
        offer(1'b1, 3'd0, 32'h1234_5677, 1'b1, 1'b1, 1'b0, 32'd0);
        tick(); scramble(); tick();
        check("al_eax", eax, 32'h1122_AB77);

        // ESP adjust then destination ESP (POP ESP).
        offer(1'b1, 3'd4, 32'h0000_2000, 1'b0, 1'b0, 1'b1, 32'h0000_1000);
        tick(); scramble(); #1;
        check("pop_busy_esp", {24'd0, busy}, SB ? 32'h10 : 32'h00);
        tick();
        check("pop_esp_n1", esp, 32'h0000_1000);
        check("pop_ready_n1", {31'd0, wb_ready}, 32'd0);
        check("pop_done_n1", {31'd0, wb_done}, 32'd0);
        tick();
        check("pop_esp_n2", esp, 32'h0000_2000);
        check("pop_done_n2", {31'd0, wb_done}, 32'd1);
        check("pop_retired", retired, 32'd4);

        // ESI full write with ESP adjust: busy mask sequence.
        offer(1'b1, 3'd6, 32'h0000_0066, 1'b0, 1'b0, 1'b1, 32'h0000_3000);
        tick(); scramble(); #1;
        check("sb_busy_wresp", {24'd0, busy}, SB ? 32'h50 : 32'h00);
        tick();
        check("sb_busy_wrdst", {24'd0, busy}, SB ? 32'h40 : 32'h00);
        check("sb_esp", esp, 32'h0000_3000);
        check("sb_esi_pending", esi, 32'd0);
        tick();
        check("sb_busy_idle", {24'd0, busy}, 32'h00);
        check("sb_esi", esi, 32'h0000_0066);

        // Back-to-back with wb_valid held high.
        offer(1'b1, 3'd1, 32'd1, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        wb_dst_value = 32'd2; #1;
        check("b2b_ready_busy", {31'd0, wb_ready}, 32'd0);
        tick();
        check("b2b_first_ecx", ecx, 32'd1);
        check("b2b_first_done", {31'd0, wb_done}, 32'd1);
        check("b2b_ready_in_done", {31'd0, wb_ready}, 32'd1);
        tick(); scramble(); tick();
        check("b2b_second_ecx", ecx, 32'd2);
        check("b2b_retired", retired, 32'd7);

        // No-op transaction still retires.
        offer(1'b0, 3'd3, 32'h5A5A_5A5A, 1'b0, 1'b0, 1'b0, 32'd0);
        tick(); scramble(); tick();
        check("noop_done", {31'd0, wb_done}, 32'd1);
        check("noop_ebx", ebx, 32'd0);
        check("noop_retired", retired, 32'd8);

        // Reset in WR_ESP aborts the transaction.
        offer(1'b1, 3'd0, 32'h5555_5555, 1'b0, 1'b0, 1'b1, 32'h0000_4444);
        tick(); scramble(); rst = 1'b1;
        tick(); rst = 1'b0; #1;
        check("abort_esp", esp, 32'd0);
        check("abort_eax", eax, 32'd0);
        check("abort_ecx", ecx, 32'd0);
        check("abort_retired", retired, 32'd0);
        check("abort_busy", {24'd0, busy}, 32'd0);
        tick();
        check("abort_no_done", {31'd0, wb_done}, 32'd0);
        check("abort_eax_after", eax, 32'd0);
        check("abort_ready", {31'd0, wb_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/opnd_writeback.md
Name: opnd_writeback

Overview:
- Sequential architectural register file and result-commit unit: the write side of operand decode.
- Accepts one retiring instruction's results per handshake: a destination-register result (operand#0) and an optional implicit ESP update.
- Applies size-correct merges (8-bit low/high, 16-bit, 32-bit) and drives the eight 32-bit GPRs that feed the operand decoder.
- Serialises the two register writes through a small FSM and counts retired instructions.

Parameters:
- RETIRE_W, 32, width of retired-instruction counter (wraps modulo 2^RETIRE_W).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- load_en  input  1  load initial register state (IDLE only).
- init_eax, init_ecx, init_edx, init_ebx, init_esp, init_ebp, init_esi, init_edi  input  32 each  initial values.
- wb_valid  input  1  transaction offered.
- wb_ready  output  1  transaction can be accepted.
- wb_dst_en  input  1  write destination register.
- wb_dst_sel  input  3  destination selector (0=EAX,1=ECX,2=EDX,3=EBX,4=ESP,5=EBP,6=ESI,7=EDI).
- wb_dst_value  input  32  destination result.
- wb_reg_1byte  input  1  8-bit destination.
- wb_operand_16bit  input  1  16-bit destination.
- wb_esp_en  input  1  implicit ESP update present.
- wb_esp_value  input  32  new ESP value (always full 32-bit).
- eax, ecx, edx, ebx, esp, ebp, esi, edi  output  32 each  architectural registers.
- wb_done  output  1  one-cycle pulse per retired transaction.
- retired  output  RETIRE_W  retired transaction count.
- busy  output  8  per-register pending-write mask (see Optional Feature).

Behaviour:
- Reset: all GPRs 0, retired 0, wb_done 0, busy 0, state IDLE; wb_ready is 1 after reset unless load_en is high. Reset mid-transaction aborts it; no partial write survives.
- States: IDLE, WR_ESP, WR_DST.
- wb_ready = (state==IDLE) && !load_en.
- In IDLE with load_en=1, all eight GPRs load from init_* at the edge. load_en has priority: wb_valid is not accepted that cycle. load_en outside IDLE is ignored.
- Accept: wb_valid && wb_ready at edge N.
  - Capture all wb_* fields into internal registers; inputs may change after acceptance.
  - Next state is WR_ESP if wb_esp_en, else WR_DST.
- WR_ESP: at the next edge, esp <= captured esp_value; go to WR_DST.
- WR_DST: at the next edge, if dst_en, merge into the destination register; go to IDLE; wb_done=1 for the following cycle; retired += 1.
- Ordering: ESP is written before the destination, so a dst_sel=4 write overrides the ESP adjust (POP ESP semantics).
- Latency: without ESP, destination visible after edge N+1; with ESP, ESP after N+1 and destination after N+2. A transaction with both enables 0 still takes WR_DST, retires, and pulses wb_done.
- Back-to-back: the cycle with wb_done=1 is in IDLE, so a new transaction may be accepted in that same cycle.
- Merge rules; wb_reg_1byte has priority over wb_operand_16bit:
  - 1-byte, sel 0-3: bits[7:0] of EAX/ECX/EDX/EBX <= value[7:0].
  - 1-byte, sel 4-7: bits[15:8] of EAX/ECX/EDX/EBX <= value[7:0] (AH/CH/DH/BH).
  - 16-bit: bits[15:0] of the selected register <= value[15:0].
  - Otherwise: full 32-bit write.
  - Unwritten bits are always preserved.

Optional Feature:
- Macro WB_SCOREBOARD_EN.
- Defined: busy bit[dst_sel] is set from the accept edge until the edge that writes it, when dst_en. busy bit[4] is set likewise when esp_en. For 1-byte sel 4-7, the set bit is [sel-4] (the containing register). All bits clear on return to IDLE.
- Undefined: busy is tied to 0.

Test Plan:
- Reset, then load_en with init_eax=0x11223344, remaining init_* = 0 -> eax=0x11223344, retired=0, wb_ready=0 during the load cycle and 1 afterwards.
- dst_sel=4, reg_1byte=1, value=0xAB, eax=0x11223344 -> eax=0x1122AB44 one edge after accept; wb_done pulses once; retired=1.
- dst_sel=2, 16bit=1, value=0xFFFF5555, edx=0xDEADBEEF -> edx=0xDEAD5555.
- esp_en=1 with esp_value=0x1000, dst_sel=4, full value 0x2000 -> esp=0x1000 after N+1, 0x2000 after N+2; wb_ready low at N+1.
- Two back-to-back transactions (ecx=1, then ecx=2), with wb_valid held high -> the second is accepted in the first's wb_done cycle; ecx=2 and retired=2 after 2 cycles. Assert rst during WR_ESP -> all registers 0 and no wb_done.
- WB_SCOREBOARD_EN defined, dst_sel=6 with esp_en=1 -> busy=0x50 through WR_ESP, 0x40 in WR_DST, 0x00 in IDLE.
